token_move_scheduler: RTL and testbench
=======================================

Name: token_move_scheduler

Overview:
- Shares one tile-stepping move engine between Player 1 and Player 2.
- Takes the instantaneous board positions from game_logic as targets and walks each displayed token toward its target one tile per STEP_FRAMES video frames.
- Outputs feed the tile_position_mapper instances, so the tokens animate instead of jumping.
- Reports busy and a move_done pulse so turn sequencing can wait for the animation.

Parameters:
- NUM_TILES, 16, number of board tiles; positions run 0..NUM_TILES-1.
- POS_W, 4, position width; must satisfy 2**POS_W >= NUM_TILES.
- STEP_FRAMES, 8, frame ticks per one-tile step (>=2).
- HOP_PX, 8, hop height in pixels (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- v_sync  in  1  VGA vertical sync (active-low pulse)
- snap  in  1  load displayed positions from targets immediately (game restart)
- p1_target  in  POS_W  game_logic P1 position
- p2_target  in  POS_W  game_logic P2 position
- disp_p1_pos  out  POS_W  animated P1 tile index
- disp_p2_pos  out  POS_W  animated P2 tile index
- busy  out  1  engine is moving a token
- active_player  out  1  token being moved (0=P1, 1=P2)
- move_done  out  1  one-cycle pulse when a move completes
- done_player  out  1  player whose move completed; valid with move_done
- hop_dy  out  8  upward pixel offset for the active token

Behaviour:
- Reset (reset=0, async) sets all of the following immediately:
  - disp_p1_pos=disp_p2_pos=0, busy=0, active_player=0, move_done=0, done_player=0, hop_dy=0
  - frame_cnt=0, last_served=1, so P1 has first priority.
  - State goes to IDLE.
- Frame tick:
  - v_sync passes through a 2-flop synchronizer.
  - A falling edge of the synchronized signal gives frame_tick, a one-cycle pulse 3 clk after the v_sync fall.
- Targets >= NUM_TILES are clamped to NUM_TILES-1 before any compare. Positions never wrap.
- IDLE:
  - Mismatch means disp != clamped target.
  - If only one player mismatches, select it.
  - If both mismatch, select !last_served (round-robin).
  - On a selection: latch active_player, clear frame_cnt, go to MOVE. busy=1 from the next cycle, so busy rises 1 cycle after the target change.
- MOVE:
  - Each frame_tick increments frame_cnt.
  - On a frame_tick with frame_cnt==STEP_FRAMES-1, the active disp steps one tile toward the live target (+1 if target>disp, else -1) and frame_cnt clears.
  - The first step therefore happens on the STEP_FRAMES-th tick after entering MOVE.
  - Any cycle with disp==target (reached, or target retargeted onto disp) goes to DONE. No further step.
  - A retarget mid-move is followed from the next step on, and the direction may reverse.
  - Changes to the non-active player's target are held until IDLE.
- DONE (1 cycle):
  - move_done=1, done_player=active_player.
  - last_served<=active_player, busy=0 next cycle, return to IDLE.
- snap=1 (synchronous, highest priority after reset):
  - Both disp load their clamped targets next cycle.
  - State goes to IDLE; frame_cnt and hop_dy clear; busy=0.
  - No move_done is issued.
- Only one disp changes at a time. The inactive disp is held.
- A frame_tick coinciding with the MOVE->DONE transition is ignored.

Optional Feature:
- Macro HOP_ANIM_EN.
- Defined:
  - In MOVE, hop_dy=HOP_PX while frame_cnt < STEP_FRAMES/2, else 0.
  - hop_dy is 0 outside MOVE.
  - The top level subtracts hop_dy from the active player's y.
- Undefined: hop_dy is tied to 0 and the hop logic is absent. The port remains.

Decomposition:
- Add to game_pkg:
  - pos_t typedef, width POS_W.
  - NUM_TILES constant.
  - mover_state_t enum {IDLE, MOVE, DONE}.
- Sub-module frame_tick_gen:
  - v_sync synchronizer plus falling-edge detect.
  - Reusable by other frame-paced blocks.

Test Plan (STEP_FRAMES=2, NUM_TILES=16 unless noted):
- After reset release, p1_target=3: disp_p1 goes 0→1→2→3, one step per 2 frame_ticks. One move_done with done_player=0 on the cycle after disp_p1=3. busy low afterward. disp_p2 stays 0.
- p1_target=2 and p2_target=1 in the same cycle after reset: P1 is served first (0→2), then P2 (0→1). Two move_done pulses, done_player 0 then 1.
- disp_p2=5, p2_target=2: steps 5→4→3→2, busy throughout, single move_done.
- P1 moving 0→6, p1_target changed to 1 when disp_p1=2: next step to 1, then DONE. No overshoot.
- snap asserted mid-MOVE with targets 7/9: next cycle disp=7/9, busy=0, no move_done pulse.
- With NUM_TILES=12, p1_target=15: P1 walks to 11 and finishes. Reset asserted mid-move zeroes all outputs without waiting for a clk edge.

Source files
------------

// File: rtl/token_move_scheduler_pkg.sv
// token_move_scheduler_pkg: shared board types, constants and helpers for the token mover.
package token_move_scheduler_pkg;
  localparam int POS_W = 4;
  localparam int NUM_TILES = 16;
  typedef logic [POS_W-1:0] pos_t;
  typedef enum logic [1:0] {IDLE, MOVE, DONE} mover_state_t;
  function automatic pos_t clamp_pos(pos_t t, int n);
    return (int'(t) >= n) ? pos_t'(n - 1) : t;
  endfunction
endpackage

// File: rtl/token_move_scheduler_if.sv
// token_move_scheduler_if: game_logic targets and v_sync in, animated token positions out.
interface token_move_scheduler_if;
  import token_move_scheduler_pkg::*;
  logic v_sync;
  logic snap;
  pos_t p1_target;
  pos_t p2_target;
  pos_t disp_p1_pos;
  pos_t disp_p2_pos;
  logic busy;
  logic active_player;
  logic move_done;
  logic done_player;
  logic [7:0] hop_dy;
  modport master (
    output v_sync, snap, p1_target, p2_target,
    input disp_p1_pos, disp_p2_pos, busy, active_player, move_done, done_player, hop_dy
  );
  modport slave (
    input v_sync, snap, p1_target, p2_target,
    output disp_p1_pos, disp_p2_pos, busy, active_player, move_done, done_player, hop_dy
  );
endinterface

// File: rtl/token_move_scheduler_frame_tick_gen.sv
// frame_tick_gen: synchronises active-low v_sync and emits a one-cycle pulse on its falling edge.
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic v_sync,
  output logic frame_tick
);
  logic [2:0] sync;
  // Reset to the idle-high level so leaving reset never looks like a frame edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '1;
    else sync <= {sync[1:0], v_sync};
  assign frame_tick = sync[2] & ~sync[1];
endmodule

// File: rtl/token_move_scheduler.sv
// token_move_scheduler: walks P1/P2 display tokens one tile per STEP_FRAMES frames toward their targets.
// Optional macro HOP_ANIM_EN drives hop_dy during the first half of each step; otherwise hop_dy is 0.
module token_move_scheduler
  import token_move_scheduler_pkg::*;
#(
  parameter int NUM_TILES = token_move_scheduler_pkg::NUM_TILES,
  parameter int STEP_FRAMES = 8
`ifdef HOP_ANIM_EN
  , parameter int HOP_PX = 8
`endif
) (
  input logic clk,
  input logic reset,
  token_move_scheduler_if.slave bus
);
  localparam int FW = $clog2(STEP_FRAMES);
  localparam logic [FW-1:0] LAST = FW'(STEP_FRAMES - 1);
  mover_state_t state, state_n;
  logic frame_tick, act, act_n, last_served, last_n, m1, m2;
  logic [FW-1:0] cnt, cnt_n;
  pos_t d1, d2, d1_n, d2_n, t1, t2, cur_d, cur_t, step;

  frame_tick_gen u_tick (.clk(clk), .rst_n(reset), .v_sync(bus.v_sync), .frame_tick(frame_tick));

  assign t1 = clamp_pos(bus.p1_target, NUM_TILES);
  assign t2 = clamp_pos(bus.p2_target, NUM_TILES);
  assign m1 = d1 != t1;
  assign m2 = d2 != t2;
  assign cur_d = act ? d2 : d1;
  assign cur_t = act ? t2 : t1;
  assign step = (cur_t > cur_d) ? cur_d + 1'b1 : cur_d - 1'b1;

  always_comb begin
    state_n = state;
    act_n = act;
    cnt_n = cnt;
    last_n = last_served;
    d1_n = d1;
    d2_n = d2;
    if (bus.snap) begin
      state_n = IDLE;
      cnt_n = '0;
      d1_n = t1;
      d2_n = t2;
    end else if (state == IDLE) begin
      if (m1 || m2) begin
        act_n = (m1 && m2) ? !last_served : m2;
        cnt_n = '0;
        state_n = MOVE;
      end
    end else if (state == MOVE) begin
      // Arrival (or a retarget onto the token) wins over a coincident frame tick
      if (cur_d == cur_t) state_n = DONE;
      else if (frame_tick) begin
        cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
        d1_n = (cnt == LAST && !act) ? step : d1;
        d2_n = (cnt == LAST && act) ? step : d2;
      end
    end else begin
      last_n = act;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      act <= 1'b0;
      cnt <= '0;
      last_served <= 1'b1;
      d1 <= '0;
      d2 <= '0;
    end else begin
      state <= state_n;
      act <= act_n;
      cnt <= cnt_n;
      last_served <= last_n;
      d1 <= d1_n;
      d2 <= d2_n;
    end

  assign bus.disp_p1_pos = d1;
  assign bus.disp_p2_pos = d2;
  assign bus.busy = state != IDLE;
  assign bus.active_player = act;
  assign bus.move_done = state == DONE;
  assign bus.done_player = act;
`ifdef HOP_ANIM_EN
  localparam logic [FW-1:0] HALF = FW'(STEP_FRAMES / 2);
  assign bus.hop_dy = (state == MOVE && cnt < HALF) ? 8'(HOP_PX) : 8'd0;
`else
  assign bus.hop_dy = 8'd0;
`endif
endmodule

// File: tb/tb_token_move_scheduler.sv
// tb_token_move_scheduler: directed checks of token stepping, arbitration, retarget, snap, clamp and reset.
module tb_token_move_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int fails = 0;
  int done_a = 0;
  int done_b = 0;
  logic dp_a = 1'b0;
  logic dp_b = 1'b0;
  int base;

  token_move_scheduler_if ifa ();
  token_move_scheduler_if ifb ();

  token_move_scheduler #(.STEP_FRAMES(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  token_move_scheduler #(.NUM_TILES(12), .STEP_FRAMES(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifa.move_done) begin done_a++; dp_a = ifa.done_player; end
    if (ifb.move_done) begin done_b++; dp_b = ifb.done_player; end
  end

  task automatic tick_fall();
    @(negedge clk);
    ifa.v_sync = 1'b0;
    ifb.v_sync = 1'b0;
    repeat (3) @(negedge clk);
    ifa.v_sync = 1'b1;
    ifb.v_sync = 1'b1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_fall();
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    ifa.p1_target = 4'd0; ifa.p2_target = 4'd0;
    ifb.p1_target = 4'd0; ifb.p2_target = 4'd0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    ifa.v_sync = 1'b1; ifa.snap = 1'b0; ifa.p1_target = 4'd0; ifa.p2_target = 4'd0;
    ifb.v_sync = 1'b1; ifb.snap = 1'b0; ifb.p1_target = 4'd0; ifb.p2_target = 4'd0;
    #1;
    checks++;
    if ({ifa.disp_p1_pos, ifa.disp_p2_pos, ifa.busy, ifa.active_player, ifa.move_done, ifa.done_player, ifa.hop_dy} !== 20'd0) begin
      fails++;
      $display("FAIL reset_outputs got p1=%0d p2=%0d busy=%b act=%b done=%b dp=%b hop=%0d exp all 0",
        ifa.disp_p1_pos, ifa.disp_p2_pos, ifa.busy, ifa.active_player, ifa.move_done, ifa.done_player, ifa.hop_dy);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ifa.busy !== 1'b0) begin fails++; $display("FAIL reset_idle busy=%b exp 0", ifa.busy); end
  endtask

  task automatic test_single_move();
    base = done_a;
    ifa.p1_target = 4'd3;
    @(negedge clk);
    checks++;
    if (ifa.busy !== 1'b1) begin fails++; $display("FAIL single_busy_rise busy=%b exp 1", ifa.busy); end
    tick(2);
    checks++;
    if (ifa.disp_p1_pos !== 4'd1) begin fails++; $display("FAIL single_step1 p1=%0d exp 1", ifa.disp_p1_pos); end
    tick(1);
    checks++;
    if (ifa.disp_p1_pos !== 4'd1) begin fails++; $display("FAIL single_hold p1=%0d exp 1", ifa.disp_p1_pos); end
    tick(1);
    checks++;
    if (ifa.disp_p1_pos !== 4'd2) begin fails++; $display("FAIL single_step2 p1=%0d exp 2", ifa.disp_p1_pos); end
    tick(1);
    tick_fall();
    checks++;
    if (ifa.disp_p1_pos !== 4'd3 || ifa.move_done !== 1'b0) begin
      fails++; $display("FAIL single_step3 p1=%0d done=%b exp 3/0", ifa.disp_p1_pos, ifa.move_done);
    end
    @(negedge clk);
    checks++;
    if (ifa.move_done !== 1'b1 || ifa.done_player !== 1'b0) begin
      fails++; $display("FAIL single_done done=%b dp=%b exp 1/0", ifa.move_done, ifa.done_player);
    end
    @(negedge clk);
    checks++;
    if (ifa.busy !== 1'b0 || ifa.move_done !== 1'b0) begin
      fails++; $display("FAIL single_after busy=%b done=%b exp 0/0", ifa.busy, ifa.move_done);
    end
    checks++;
    if (ifa.disp_p2_pos !== 4'd0 || done_a != base + 1) begin
      fails++; $display("FAIL single_p2_hold p2=%0d dones=%0d exp 0/%0d", ifa.disp_p2_pos, done_a - base, 1);
    end
  endtask

  task automatic test_both_priority();
    do_reset();
    base = done_a;
    ifa.p1_target = 4'd2;
    ifa.p2_target = 4'd1;
    @(negedge clk);
    checks++;
    if (ifa.busy !== 1'b1 || ifa.active_player !== 1'b0) begin
      fails++; $display("FAIL both_first busy=%b act=%b exp 1/0", ifa.busy, ifa.active_player);
    end
    tick(4);
    checks++;
    if (ifa.disp_p1_pos !== 4'd2 || ifa.disp_p2_pos !== 4'd0 || done_a != base + 1 || dp_a !== 1'b0) begin
      fails++; $display("FAIL both_p1_done p1=%0d p2=%0d dones=%0d dp=%b exp 2/0/1/0",
        ifa.disp_p1_pos, ifa.disp_p2_pos, done_a - base, dp_a);
    end
    checks++;
    if (ifa.busy !== 1'b1 || ifa.active_player !== 1'b1) begin
      fails++; $display("FAIL both_second busy=%b act=%b exp 1/1", ifa.busy, ifa.active_player);
    end
    tick(2);
    checks++;
    if (ifa.disp_p2_pos !== 4'd1 || done_a != base + 2 || dp_a !== 1'b1 || ifa.busy !== 1'b0) begin
      fails++; $display("FAIL both_p2_done p2=%0d dones=%0d dp=%b busy=%b exp 1/2/1/0",
        ifa.disp_p2_pos, done_a - base, dp_a, ifa.busy);
    end
  endtask

  task automatic test_move_down();
    ifa.p2_target = 4'd5;
    ifa.snap = 1'b1;
    @(negedge clk);
    ifa.snap = 1'b0;
    checks++;
    if (ifa.disp_p2_pos !== 4'd5) begin fails++; $display("FAIL down_snap p2=%0d exp 5", ifa.disp_p2_pos); end
    base = done_a;
    ifa.p2_target = 4'd2;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      if (i < 6) begin
        checks++;
        if (ifa.busy !== 1'b1) begin fails++; $display("FAIL down_busy tick=%0d busy=%b exp 1", i, ifa.busy); end
      end
      if (i % 2 == 0) begin
        checks++;
        if (ifa.disp_p2_pos !== 4'(5 - i / 2)) begin
          fails++; $display("FAIL down_step tick=%0d p2=%0d exp %0d", i, ifa.disp_p2_pos, 5 - i / 2);
        end
      end
    end
    checks++;
    if (done_a != base + 1 || ifa.busy !== 1'b0 || ifa.disp_p1_pos !== 4'd2) begin
      fails++; $display("FAIL down_done dones=%0d busy=%b p1=%0d exp 1/0/2", done_a - base, ifa.busy, ifa.disp_p1_pos);
    end
  endtask

  task automatic test_retarget();
    ifa.p1_target = 4'd0;
    ifa.snap = 1'b1;
    @(negedge clk);
    ifa.snap = 1'b0;
    base = done_a;
    ifa.p1_target = 4'd6;
    tick(4);
    checks++;
    if (ifa.disp_p1_pos !== 4'd2) begin fails++; $display("FAIL retarget_mid p1=%0d exp 2", ifa.disp_p1_pos); end
    ifa.p1_target = 4'd1;
    tick(1);
    checks++;
    if (ifa.disp_p1_pos !== 4'd2 || ifa.busy !== 1'b1) begin
      fails++; $display("FAIL retarget_hold p1=%0d busy=%b exp 2/1", ifa.disp_p1_pos, ifa.busy);
    end
    tick(1);
    checks++;
    if (ifa.disp_p1_pos !== 4'd1 || done_a != base + 1 || ifa.busy !== 1'b0) begin
      fails++; $display("FAIL retarget_end p1=%0d dones=%0d busy=%b exp 1/1/0", ifa.disp_p1_pos, done_a - base, ifa.busy);
    end
  endtask

  task automatic test_snap();
    base = done_a;
    ifa.p1_target = 4'd5;
    tick(1);
    checks++;
    if (ifa.busy !== 1'b1) begin fails++; $display("FAIL snap_pre busy=%b exp 1", ifa.busy); end
    ifa.p1_target = 4'd7;
    ifa.p2_target = 4'd9;
    ifa.snap = 1'b1;
    @(negedge clk);
    ifa.snap = 1'b0;
    checks++;
    if (ifa.disp_p1_pos !== 4'd7 || ifa.disp_p2_pos !== 4'd9 || ifa.busy !== 1'b0 || ifa.hop_dy !== 8'd0) begin
      fails++; $display("FAIL snap_load p1=%0d p2=%0d busy=%b hop=%0d exp 7/9/0/0",
        ifa.disp_p1_pos, ifa.disp_p2_pos, ifa.busy, ifa.hop_dy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_a != base || ifa.busy !== 1'b0) begin
      fails++; $display("FAIL snap_no_done dones=%0d busy=%b exp 0/0", done_a - base, ifa.busy);
    end
  endtask

  task automatic test_clamp_and_async_reset();
    ifb.p1_target = 4'd15;
    tick(22);
    checks++;
    if (ifb.disp_p1_pos !== 4'd11 || done_b != 1 || dp_b !== 1'b0 || ifb.busy !== 1'b0) begin
      fails++; $display("FAIL clamp_end p1=%0d dones=%0d dp=%b busy=%b exp 11/1/0/0",
        ifb.disp_p1_pos, done_b, dp_b, ifb.busy);
    end
    tick(2);
    checks++;
    if (ifb.disp_p1_pos !== 4'd11 || done_b != 1) begin
      fails++; $display("FAIL clamp_hold p1=%0d dones=%0d exp 11/1", ifb.disp_p1_pos, done_b);
    end
    ifb.p2_target = 4'd15;
    tick(4);
    checks++;
    if (ifb.disp_p2_pos !== 4'd2 || ifb.busy !== 1'b1 || ifb.active_player !== 1'b1) begin
      fails++; $display("FAIL clamp_p2_mid p2=%0d busy=%b act=%b exp 2/1/1", ifb.disp_p2_pos, ifb.busy, ifb.active_player);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ifb.disp_p1_pos, ifb.disp_p2_pos, ifb.busy, ifb.active_player, ifb.move_done, ifb.done_player, ifb.hop_dy} !== 20'd0) begin
      fails++; $display("FAIL async_reset p1=%0d p2=%0d busy=%b act=%b done=%b dp=%b hop=%0d exp all 0",
        ifb.disp_p1_pos, ifb.disp_p2_pos, ifb.busy, ifb.active_player, ifb.move_done, ifb.done_player, ifb.hop_dy);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_both_priority();
    test_move_down();
    test_retarget();
    test_snap();
    test_clamp_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
